// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers UART_RX writes and launches one UART_TX strobe per byte, paced off TX Active/Done.
// Optional status outputs (o_Count, o_Overflow) are enabled by defining UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  input  logic                  i_TX_Active,
  input  logic                  i_TX_Done,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  output logic                  o_Empty,
  output logic                  o_Full
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GUARD} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  full, pop, push;

  assign full = (count == DEPTH_CNT);
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
  assign push = i_Wr_DV && (!full || pop);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !i_TX_Active) begin
          pop       = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: if (i_TX_Done) state_nxt = GUARD;
      GUARD:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= 8'h00;
      o_Empty   <= 1'b1;
      o_Full    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      o_Empty <= (count_nxt == '0);
      o_Full  <= (count_nxt == DEPTH_CNT);
      o_TX_DV <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_TX_Byte <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push && !i_Reset) mem[wr_ptr] <= i_Wr_Byte;
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign o_Count = count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset)                        o_Overflow <= 1'b0;
    else if (i_Wr_DV && full && !pop)   o_Overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo with a queue-based reference model and a simple UART_TX responder.
module tb_uart_tx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] wbyte = 8'h00;
  logic       tx_act = 1'b0, hold_act = 1'b0, tx_done = 1'b0;
  logic       active;
  logic       o_TX_DV, o_Empty, o_Full;
  logic [7:0] o_TX_Byte;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [DL:0] o_Count;
  logic        o_Overflow;
`endif

  assign active = tx_act | hold_act;
  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr), .i_Wr_Byte(wbyte),
    .i_TX_Active(active), .i_TX_Done(tx_done),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_Empty(o_Empty), .o_Full(o_Full)
`ifdef UART_TX_FIFO_STATUS_EN
    , .o_Count(o_Count), .o_Overflow(o_Overflow)
`endif
  );

  typedef struct {logic [7:0] b; int unsigned cyc;} exp_t;
  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  int unsigned cyc = 0;
  bit          m_wait = 0, m_guard = 0, m_ovf = 0;
  logic [7:0]  m_last = 8'h00;
  bit          chk_en = 0, dv_seen = 0;
  int          busy = 0;
  int          checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: a byte queue; a launch needs a byte, TX not active, and the
  // previous launch retired by Done plus one settling cycle.
  initial begin
    forever begin
      @(posedge clk);
      begin
        int unsigned cur;
        int          sz;
        bit          launch;
        logic [7:0]  b;
        cur = cyc;
        launch = 0;
        if (rst) begin
          mq.delete();
          m_wait = 0; m_guard = 0; m_ovf = 0; m_last = 8'h00;
        end else begin
          sz = mq.size();
          if (m_wait) begin
            if (tx_done) begin m_wait = 0; m_guard = 1; end
          end else if (m_guard) m_guard = 0;
          else if (sz != 0 && !active) launch = 1;
          if (launch) begin
            b = mq.pop_front();
            m_last = b;
            exp_q.push_back('{b, cur + 1});
            m_wait = 1;
          end
          if (wr) begin
            if (sz < DEPTH || launch) mq.push_back(wbyte);
            else m_ovf = 1;
          end
        end
        cyc = cur + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on each launch strobe and checks status flags.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          chk("missed_dv", exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (o_TX_DV === 1'b1) begin
          dv_seen = 1;
          if (exp_q.size() == 0) chk("unexpected_dv", 32'(o_TX_Byte), 32'hFFFF_FFFF);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tx_byte", 32'(o_TX_Byte), 32'(e.b));
            chk("tx_cycle", cyc, e.cyc);
          end
        end
        chk("empty", 32'(o_Empty), 32'(mq.size() == 0));
        chk("full", 32'(o_Full), 32'(mq.size() == DEPTH));
        chk("held_byte", 32'(o_TX_Byte), 32'(m_last));
`ifdef UART_TX_FIFO_STATUS_EN
        chk("count", 32'(o_Count), mq.size());
        chk("overflow", 32'(o_Overflow), 32'(m_ovf));
`endif
      end
    end
  end

  // UART_TX stand-in: busy for a random span after each launch, then a Done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (busy == 1) begin busy = 0; tx_act = 1'b0; tx_done = 1'b1; end
      else if (busy > 1) busy--;
      if (dv_seen) begin
        dv_seen = 0;
        busy = $urandom_range(2, 8);
        tx_act = 1'b1;
      end
    end
  end

  task automatic step(input bit w, input logic [7:0] b);
    @(posedge clk); #1;
    wr = w; wbyte = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step(0, 8'h00);
      if (exp_q.size() == 0 && mq.size() == 0 && busy == 0 && !m_wait && !m_guard && !tx_done) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    repeat (3) step(0, 8'h00);
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_tx_dv", 32'(o_TX_DV), 32'd0);
    chk("rst_tx_byte", 32'(o_TX_Byte), 32'h00);
    chk("rst_empty", 32'(o_Empty), 32'd1);
    chk("rst_full", 32'(o_Full), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single byte
    step(1, 8'hA5);
    step(0, 8'h00);
    drain();

    // burst of five
    foreach (mq[i]) ;
    for (int i = 1; i <= 5; i++) step(1, 8'(i * 8'h11));
    drain();

    // fill past capacity while TX is held busy
    do_reset();
    hold_act = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h60 + i));
    step(0, 8'h00);
    repeat (3) step(0, 8'h00);
    hold_act = 1'b0;
    drain();

    // full FIFO: TX goes idle in the same cycle as a write
    do_reset();
    hold_act = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h80 + i));
    step(0, 8'h00);
    @(posedge clk); #1;
    hold_act = 1'b0; wr = 1'b1; wbyte = 8'hEE;
    step(0, 8'h00);
    drain();

    // pointer wrap: 40 bytes streamed at TX pace
    begin
      int n;
      n = 0;
      for (int c = 0; c < 5000 && n < 40; c++) begin
        if (mq.size() < DEPTH - 1 && $urandom_range(0, 3) == 0) begin
          step(1, 8'(n));
          n++;
        end else step(0, 8'h00);
      end
      chk("wrap_written", n, 40);
    end
    drain();

    // reset while bytes are queued and TX is active
    hold_act = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i));
    step(0, 8'h00);
    do_reset();
    @(negedge clk);
    chk("midrst_empty", 32'(o_Empty), 32'd1);
    chk("midrst_dv", 32'(o_TX_DV), 32'd0);
    step(1, 8'h77);
    repeat (4) step(0, 8'h00);
    hold_act = 1'b0;
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) hold_act = ~hold_act;
      step($urandom_range(0, 1) == 1, 8'($urandom));
    end
    hold_act = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
